led_scan_rx: RTL and testbench
==============================

Name: led_scan_rx

Overview:
- Receive-side counterpart of the six-digit multiplexed seven-segment scan driver.
- Samples the common-node enables, segment bus and decimal point, and rebuilds the full 42-bit six-digit segment image and the 6-bit dp vector.
- Decodes each digit back to BCD and flags frame completion, scan errors and loss of scan.
- Used as a loop-back checker for the display path and as a capture front end for an external display bus.

Parameters:
SETTLE_CYC, 4, consecutive clk cycles the synchronised {enb,seg,dp} must hold before capture (legal range 1..255)
TIMEOUT_CYC, 200000, clk cycles without any capture before the frame is declared lost (legal range 2..2^24-1)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
i_seg_enb  input  6  common-node enables, active-low, one-cold; bit k selects digit k
i_seg  input  7  segment pattern {a,b,c,d,e,f,g}, active-high
i_seg_dp  input  1  decimal point of the selected digit
o_six_digit_seg  output  42  captured image; digit k occupies bits [7k+6:7k]
o_six_dp  output  6  captured dp; bit k belongs to digit k
o_digit_bcd  output  24  decoded digits; digit k occupies bits [4k+3:4k]
o_frame_valid  output  1  high while a complete, non-stale frame is held
o_frame_stb  output  1  one-cycle pulse on each completed frame
o_err_multi  output  1  one-cycle pulse when more than one enable is low on a capture

Behaviour:
- Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values:
  - o_six_digit_seg = 0, o_six_dp = 0.
  - o_frame_valid = 0, o_frame_stb = 0, o_err_multi = 0.
  - seen[5:0] = 0, synchronisers = all-ones enb / zero seg and dp.
  - Stability and timeout counters = 0.
- Input sync: every input passes a 2-flop synchroniser. Synced value S is the input delayed 2 clk.
- Stability counter:
  - Clears to 0 when S differs from S of the previous cycle.
  - Otherwise increments, saturating at SETTLE_CYC.
  - A capture event fires exactly once per stable period, in the cycle the counter goes from SETTLE_CYC-1 to SETTLE_CYC.
- Capture timing: input constant from edge N gives updated capture registers at edge N+2+SETTLE_CYC.
- Capture event, by the value of S.enb:
  - Exactly one zero at index k: slot k <= S.seg, o_six_dp[k] <= S.dp, seen[k] <= 1, timeout counter <= 0.
  - All ones (blanking gap): no write; timeout counter keeps running.
  - Two or more zeros: no write, seen unchanged, o_err_multi pulses 1 cycle (registered with the capture edge). The timeout counter is not cleared.
- Frame completion: a capture of k=5 while seen[4:0]==5'b11111 does all of the following on the same edge as the slot write:
  - o_frame_stb pulses.
  - o_frame_valid <= 1.
  - seen <= 0.
- Out-of-order scan: capture of k=5 with seen incomplete writes the slot, then clears seen with no strobe. Re-capturing an already-seen slot just overwrites it.
- Timeout:
  - The counter increments every cycle not cleared by a valid capture.
  - On reaching TIMEOUT_CYC: o_frame_valid <= 0, seen <= 0, and the counter holds until the next valid capture.
  - Captured image and dp are retained.
- Decode (combinational from slot registers) per digit:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4.
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9.
  - 0000000->4'hE (blank); any other pattern->4'hF (invalid).
- Simultaneous events: a valid capture and timeout expiry in the same cycle resolve to the capture (counter cleared, o_frame_valid unaffected by timeout).
- Reset mid-frame immediately returns all state to reset values. The partial frame is discarded and no strobe is produced.

Test Plan:
- Reset: assert rst_n=0 mid-scan -> all outputs 0, o_digit_bcd=24'hEEEEEE, no o_frame_stb after release until a full new 0..5 scan.
- Normal scan: enb 111110..011111 each held 1000 clk with segs for 5,9 in digits 0,1 and 0000000 elsewhere -> o_frame_stb single pulse after digit 5 capture, o_six_digit_seg[13:0]={1110011,1011011}, o_digit_bcd=24'hEEEE95, o_frame_valid=1.
- Settle filter: seg glitch of SETTLE_CYC-1=3 cycles on digit 2 before the stable value -> only the stable pattern is captured, exactly one capture per phase, capture at edge N+6.
- Multi-enable: enb=111100 held 10 cycles -> o_err_multi one pulse, slots 0/1 unchanged, seen unchanged.
- Out-of-order: scan 0,1,2,5 -> no o_frame_stb, seen cleared; then full 0..5 -> one o_frame_stb.
- Timeout: TIMEOUT_CYC=100, complete a frame then hold enb=111111 -> o_frame_valid falls exactly 100 clk after last capture, image retained. A capture on the expiry cycle keeps o_frame_valid=1.

Source files
------------

// File: rtl/led_scan_rx.sv
// led_scan_rx: rebuilds a six-digit seven-segment image from a multiplexed scan bus
// Ports:
//   clk, rst_n        50 MHz clock, asynchronous active-low reset
//   i_seg_enb[5:0]    active-low one-cold digit enables, bit k selects digit k
//   i_seg[6:0]        segment pattern {a,b,c,d,e,f,g} of the selected digit
//   i_seg_dp          decimal point of the selected digit
//   o_six_digit_seg   captured image, digit k at [7k+6:7k]
//   o_six_dp          captured decimal points, bit k for digit k
//   o_digit_bcd       per-digit decode, digit k at [4k+3:4k] (E blank, F invalid)
//   o_frame_valid     high while a complete, non-stale frame is held
//   o_frame_stb       one-cycle pulse per completed frame
//   o_err_multi       one-cycle pulse on a capture with several enables low
module led_scan_rx #(
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  i_seg_enb,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   output logic [41:0] o_six_digit_seg,
   output logic [5:0]  o_six_dp,
   output logic [23:0] o_digit_bcd,
   output logic        o_frame_valid,
   output logic        o_frame_stb,
   output logic        o_err_multi
);
   localparam logic [13:0] SYNC_RST = {6'h3f, 8'h00};
   localparam logic [7:0]  SETTLE   = 8'(SETTLE_CYC);
   localparam logic [23:0] TIMEOUT  = 24'(TIMEOUT_CYC);
   // bus packed as {enb, seg, dp}: first sync flop, synced value, synced value one cycle earlier
   logic [13:0] sm, ss, sp;
   logic [7:0]  stab;
   logic [23:0] tcnt;
   logic [5:0]  seen;
   logic [2:0]  zeros, idx;
   logic        cap, valid, multi, done, expire;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sm <= SYNC_RST;
         ss <= SYNC_RST;
         sp <= SYNC_RST;
      end else begin
         sm <= {i_seg_enb, i_seg, i_seg_dp};
         ss <= sm;
         sp <= ss;
      end
   end
   // saturating run length of an unchanged bus; the capture fires on the single step into saturation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stab <= '0;
      else stab <= (ss != sp) ? '0 : (stab == SETTLE) ? stab : stab + 8'd1;
   end
   assign cap = (ss == sp) && (stab == SETTLE - 8'd1);
   always_comb begin
      zeros = '0;
      idx   = '0;
      for (int k = 0; k < 6; k++)
         if (!ss[8+k]) begin
            zeros = zeros + 3'd1;
            idx   = 3'(k);
         end
   end
   assign valid  = cap && (zeros == 3'd1);
   assign multi  = cap && (zeros > 3'd1);
   assign done   = valid && (idx == 3'd5) && (&seen[4:0]);
   // a valid capture in the expiry cycle wins over the timeout
   assign expire = !valid && (tcnt == TIMEOUT - 24'd1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_six_digit_seg <= '0;
         o_six_dp        <= '0;
         o_frame_valid   <= 1'b0;
         o_frame_stb     <= 1'b0;
         o_err_multi     <= 1'b0;
         seen            <= '0;
         tcnt            <= '0;
      end else begin
         o_frame_stb   <= done;
         o_err_multi   <= multi;
         tcnt          <= valid ? '0 : (tcnt == TIMEOUT) ? tcnt : tcnt + 24'd1;
         for (int k = 0; k < 6; k++)
            if (valid && idx == 3'(k)) begin
               o_six_digit_seg[7*k +: 7] <= ss[7:1];
               o_six_dp[k]               <= ss[0];
            end
         o_frame_valid <= done ? 1'b1 : expire ? 1'b0 : o_frame_valid;
         // digit 5 always closes the frame attempt, complete or not
         seen          <= valid ? ((idx == 3'd5) ? 6'd0 : seen | (6'd1 << idx)) : expire ? 6'd0 : seen;
      end
   end
   function automatic logic [3:0] dec(input logic [6:0] p);
      case (p)
         7'b1111110: dec = 4'd0;
         7'b0110000: dec = 4'd1;
         7'b1101101: dec = 4'd2;
         7'b1111001: dec = 4'd3;
         7'b0110011: dec = 4'd4;
         7'b1011011: dec = 4'd5;
         7'b1011111: dec = 4'd6;
         7'b1110000: dec = 4'd7;
         7'b1111111: dec = 4'd8;
         7'b1110011: dec = 4'd9;
         7'b0000000: dec = 4'hE;
         default:    dec = 4'hF;
      endcase
   endfunction
   always_comb
      for (int k = 0; k < 6; k++) o_digit_bcd[4*k +: 4] = dec(o_six_digit_seg[7*k +: 7]);
endmodule

// File: tb/tb_led_scan_rx.sv
// tb_led_scan_rx: self-checking bench for led_scan_rx against a sample-history reference model
module tb_led_scan_rx;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;
   localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                       7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [5:0]  enb = 6'h3f;
   logic [6:0]  seg = '0;
   logic        dp = 1'b0;
   logic [41:0] six_seg;
   logic [5:0]  six_dp;
   logic [23:0] bcd;
   logic        fv, stb, err;
   int checks = 0, failures = 0, stb_cnt = 0, err_cnt = 0;
   // reference model state
   logic [13:0] hist[$];
   logic [6:0]  m_img [6];
   logic [5:0]  m_dp, m_seen;
   logic        m_fv, m_stb, m_err;
   int          edge_no, last_cap;

   typedef struct {
      logic [5:0]  enb;
      logic [6:0]  seg;
      logic        dp;
      int          hold;
      logic [23:0] bcd;
      logic [5:0]  dpv;
      logic        fv;
      int          stbs;
      int          errs;
   } vec_t;
   vec_t tbl [11];

   led_scan_rx #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .i_seg_enb(enb), .i_seg(seg), .i_seg_dp(dp),
      .o_six_digit_seg(six_seg), .o_six_dp(six_dp), .o_digit_bcd(bcd),
      .o_frame_valid(fv), .o_frame_stb(stb), .o_err_multi(err));

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] dec(input logic [6:0] p);
      dec = (p == 7'd0) ? 4'hE : 4'hF;
      for (int d = 0; d < 10; d++) if (PAT[d] == p) dec = 4'(d);
   endfunction

   function automatic logic [41:0] m_image();
      for (int k = 0; k < 6; k++) m_image[7*k +: 7] = m_img[k];
   endfunction

   function automatic logic [23:0] m_bcd();
      for (int k = 0; k < 6; k++) m_bcd[4*k +: 4] = dec(m_img[k]);
   endfunction

   function automatic logic [5:0] sel(input int k);
      sel = ~(6'd1 << k);
   endfunction

   // history starts as if the reset bus value had always been present
   task automatic model_reset();
      hist.delete();
      repeat (SETTLE + 3) hist.push_back({6'h3f, 8'h00});
      for (int k = 0; k < 6; k++) m_img[k] = '0;
      m_dp = '0; m_seen = '0; m_fv = 0; m_stb = 0; m_err = 0;
      edge_no = 0; last_cap = 0;
   endtask

   // a capture happens at edge E when the samples of edges E-2-SETTLE..E-2 agree
   // and the sample of edge E-3-SETTLE differs (one capture per stable run)
   task automatic model_edge();
      logic [13:0] v;
      bit stable, valid;
      int zeros, k;
      edge_no++;
      hist.push_back({enb, seg, dp});
      if (hist.size() > SETTLE + 4) hist.delete(0);
      stable = (hist[0] != hist[1]);
      for (int i = 2; i <= SETTLE + 1; i++) if (hist[i] != hist[1]) stable = 0;
      v = hist[1];
      m_stb = 0; m_err = 0; valid = 0;
      if (stable) begin
         zeros = 0; k = 0;
         for (int i = 0; i < 6; i++) if (!v[8+i]) begin zeros++; k = i; end
         if (zeros == 1) begin
            valid = 1; last_cap = edge_no;
            m_img[k] = v[7:1]; m_dp[k] = v[0];
            if (k == 5) begin
               if (m_seen[4:0] == 5'h1f) begin m_stb = 1; m_fv = 1; end
               m_seen = '0;
            end else m_seen[k] = 1'b1;
         end else if (zeros > 1) m_err = 1;
      end
      if (!valid && edge_no - last_cap == TIMEOUT) begin m_fv = 0; m_seen = '0; end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("image", six_seg, m_image());
      chk("dp", six_dp, m_dp);
      chk("bcd", bcd, m_bcd());
      chk("frame_valid", fv, m_fv);
      chk("frame_stb", stb, m_stb);
      chk("err_multi", err, m_err);
      stb_cnt += int'(stb);
      err_cnt += int'(err);
   endtask

   task automatic phase(input logic [5:0] e, input logic [6:0] s, input logic d, input int n);
      enb = e; seg = s; dp = d;
      repeat (n) tick();
   endtask

   task automatic scan(input int first, input int last, input int hold);
      for (int k = first; k <= last; k++) phase(sel(k), PAT[k], k % 2 == 1, hold);
   endtask

   initial begin
      int r, ptr, hold, a, b;
      logic [5:0] e;
      logic [6:0] s;
      tbl[0]  = '{6'b111110, PAT[5], 1'b0, 20, 24'hEEEEE5, 6'h00, 1'b0, 0, 0};
      tbl[1]  = '{6'b111101, PAT[9], 1'b1, 20, 24'hEEEE95, 6'h02, 1'b0, 0, 0};
      tbl[2]  = '{6'b111011, 7'h00,  1'b0, 20, 24'hEEEE95, 6'h02, 1'b0, 0, 0};
      tbl[3]  = '{6'b110111, 7'h00,  1'b0, 20, 24'hEEEE95, 6'h02, 1'b0, 0, 0};
      tbl[4]  = '{6'b101111, 7'h00,  1'b0, 20, 24'hEEEE95, 6'h02, 1'b0, 0, 0};
      tbl[5]  = '{6'b011111, 7'h00,  1'b0, 20, 24'hEEEE95, 6'h02, 1'b1, 1, 0};
      tbl[6]  = '{6'b111100, PAT[8], 1'b0, 10, 24'hEEEE95, 6'h02, 1'b1, 0, 1};
      tbl[7]  = '{6'b111111, PAT[8], 1'b1, 10, 24'hEEEE95, 6'h02, 1'b1, 0, 0};
      tbl[8]  = '{6'b111110, PAT[0], 1'b1, 20, 24'hEEEE90, 6'h03, 1'b1, 0, 0};
      tbl[9]  = '{6'b111101, PAT[3], 1'b0, 20, 24'hEEEE30, 6'h01, 1'b1, 0, 0};
      tbl[10] = '{6'b011111, PAT[1], 1'b0, 20, 24'h1EEE30, 6'h01, 1'b1, 0, 0};
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset image", six_seg, 42'd0);
      chk("reset dp", six_dp, 6'd0);
      chk("reset bcd", bcd, 24'hEEEEEE);
      chk("reset valid", fv, 1'b0);
      chk("reset stb", stb, 1'b0);
      chk("reset err", err, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         stb_cnt = 0; err_cnt = 0;
         phase(tbl[i].enb, tbl[i].seg, tbl[i].dp, tbl[i].hold);
         chk($sformatf("vec%0d bcd", i), bcd, tbl[i].bcd);
         chk($sformatf("vec%0d dp", i), six_dp, tbl[i].dpv);
         chk($sformatf("vec%0d valid", i), fv, tbl[i].fv);
         chk($sformatf("vec%0d strobes", i), stb_cnt, tbl[i].stbs);
         chk($sformatf("vec%0d multi", i), err_cnt, tbl[i].errs);
      end
      // a 3-cycle glitch on digit 2 is filtered; the stable value lands 7 edges after it appears
      phase(6'b111011, PAT[1], 1'b0, 3);
      phase(6'b111011, PAT[7], 1'b0, 6);
      chk("settle before capture", bcd[11:8], 4'hE);
      phase(6'b111011, PAT[7], 1'b0, 1);
      chk("settle capture", bcd[11:8], 4'h7);
      phase(6'b111011, PAT[7], 1'b0, 10);
      chk("settle held", bcd[11:8], 4'h7);
      // out-of-order scan gives no strobe; a following full scan gives exactly one
      stb_cnt = 0;
      scan(0, 2, 12);
      phase(sel(5), PAT[5], 1'b1, 12);
      chk("out-of-order strobes", stb_cnt, 0);
      stb_cnt = 0;
      scan(0, 5, 12);
      chk("full scan strobes", stb_cnt, 1);
      // timeout 100 edges after the last capture, image retained
      scan(0, 4, 10);
      phase(sel(5), PAT[5], 1'b1, 7);
      chk("frame stb edge", stb, 1'b1);
      phase(sel(5), PAT[5], 1'b1, 99);
      chk("valid before timeout", fv, 1'b1);
      phase(sel(5), PAT[5], 1'b1, 1);
      chk("valid at timeout", fv, 1'b0);
      chk("timeout keeps image", bcd, 24'h543210);
      // capture landing on the expiry edge keeps the frame valid
      scan(0, 4, 10);
      phase(sel(5), PAT[5], 1'b1, 7);
      chk("second frame valid", fv, 1'b1);
      phase(sel(5), PAT[5], 1'b1, 93);
      phase(sel(0), PAT[9], 1'b0, 7);
      chk("capture beats timeout", fv, 1'b1);
      chk("capture on expiry edge", bcd[3:0], 4'h9);
      // randomized scans, glitches, blanks and multi-enable phases
      ptr = 0;
      for (int p = 0; p < 300; p++) begin
         r = $urandom_range(0, 9);
         hold = $urandom_range(1, 12);
         if (r < 6) begin
            e = sel(ptr);
            ptr = (ptr + 1) % 6;
         end else if (r == 6) e = sel($urandom_range(0, 5));
         else if (r == 7) begin
            e = 6'h3f;
            hold = $urandom_range(1, 130);
         end else begin
            a = $urandom_range(0, 5);
            b = (a + 1 + $urandom_range(0, 4)) % 6;
            e = ~((6'd1 << a) | (6'd1 << b)) & 6'($urandom);
         end
         s = ($urandom_range(0, 3) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 9)];
         phase(e, s, 1'($urandom), hold);
      end
      // reset mid-frame discards the partial frame
      scan(0, 2, 12);
      rst_n = 1'b0;
      #1;
      chk("mid reset image", six_seg, 42'd0);
      chk("mid reset dp", six_dp, 6'd0);
      chk("mid reset bcd", bcd, 24'hEEEEEE);
      chk("mid reset valid", fv, 1'b0);
      chk("mid reset stb", stb, 1'b0);
      chk("mid reset err", err, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      stb_cnt = 0;
      scan(3, 5, 12);
      chk("no strobe after reset", stb_cnt, 0);
      scan(0, 5, 12);
      chk("strobe after new scan", stb_cnt, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
